// File: rtl/twos_to_sign_mag_serial.sv
// twos_to_sign_mag_serial
// Converts a two's-complement word into sign-magnitude form. The magnitude is
// negated one bit per cycle, LSB first, with the rule "copy bits up to and
// including the first one, invert every bit after it", so no MIC-wide adder
// is needed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data is offered
//   in_ready   block can accept a word (IDLE only)
//   in_data    two's-complement operand, MIC bits
//   out_valid  out_data/out_ovf valid, held until out_ready
//   out_ready  consumer takes the result
//   out_data   sign-magnitude result, [MIC-1] = sign, [MIC-2:0] = magnitude
//   out_ovf    input was -2^(MIC-1); out_data then saturates to {1, all ones}
//   busy       high while converting or holding a result
module twos_to_sign_mag_serial #(
    parameter int MIC = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [MIC-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [MIC-1:0] out_data,
    output logic           out_ovf,
    output logic           busy
);

    // Counter must index MIC-1 magnitude bits; keep it at least one bit wide.
    localparam int CW = (MIC > 2) ? $clog2(MIC - 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic           sign;
    logic [MIC-2:0] sr;
    logic [MIC-2:0] res;
    logic [CW-1:0]  cnt;
    logic           seen_one;
    logic [MIC-1:0] out_data_r;
    logic           out_ovf_r;

    logic           b;
    logic           r;
    logic           last_bit;
    logic [MIC-1:0] res_ext;
    logic [MIC-2:0] res_nx;

    // Bit-serial negation step. The new bit enters the result from the MSB
    // side so that after MIC-1 shifts every bit is back in its own position.
    always_comb begin
        b        = sr[0];
        r        = (sign && seen_one) ? ~b : b;
        last_bit = (cnt == CW'(MIC - 2));
        res_ext  = {r, res};
        res_nx   = res_ext[MIC-1:1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            seen_one   <= 1'b0;
            out_data_r <= '0;
            out_ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign     <= in_data[MIC-1];
                        sr       <= in_data[MIC-2:0];
                        res      <= '0;
                        cnt      <= '0;
                        seen_one <= 1'b0;
                    end
                end
                SHIFT: begin
                    sr       <= sr >> 1;
                    res      <= res_nx;
                    seen_one <= seen_one | b;
                    cnt      <= cnt + CW'(1);
                    if (last_bit) begin
                        // A negative word with no one in its magnitude is the
                        // most negative value, which has no sign-magnitude form.
                        if (sign && !(seen_one || b)) begin
                            out_data_r <= '1;
                            out_ovf_r  <= 1'b1;
                        end else begin
                            out_data_r <= {sign, res_nx};
                            out_ovf_r  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_data_r;
    assign out_ovf  = out_ovf_r;

endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
module tb_twos_to_sign_mag_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv3, ir3, ov3, or3, ovf3, busy3;
    logic [2:0] id3, od3;
    logic       iv8, ir8, ov8, or8, ovf8, busy8;
    logic [7:0] id8, od8;

    int tests = 0;
    int fails = 0;

    twos_to_sign_mag_serial #(.MIC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3),
        .out_ovf(ovf3), .busy(busy3)
    );

    twos_to_sign_mag_serial #(.MIC(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8),
        .out_ovf(ovf8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: interpret the word as a signed integer and write it down in
    // sign-magnitude form. Result is {ovf, data}.
    function automatic logic [8:0] model(input int w, input logic [7:0] d);
        int u, v, half;
        half = 1 << (w - 1);
        u = int'(d) & ((1 << w) - 1);
        v = (u >= half) ? u - (1 << w) : u;
        if (v == -half) return {1'b1, 8'((1 << w) - 1)};
        if (v < 0)      return {1'b0, 8'(half + (-v))};
        return {1'b0, 8'(v)};
    endfunction

    function automatic logic [8:0] res_of(input int w);
        if (w == 3) return {ovf3, 5'b0, od3};
        return {ovf8, od8};
    endfunction

    // {out_valid, in_ready, busy}
    function automatic logic [2:0] ctl(input int w);
        if (w == 3) return {ov3, ir3, busy3};
        return {ov8, ir8, busy8};
    endfunction

    task automatic drive(input int w, input logic v, input logic [7:0] d);
        if (w == 3) begin iv3 = v; id3 = d[2:0]; end
        else        begin iv8 = v; id8 = d;      end
    endtask

    task automatic set_ready(input int w, input logic r);
        if (w == 3) or3 = r;
        else        or8 = r;
    endtask

    // One full transaction with directed latency/handshake checks. While the
    // block is busy in_valid is held high with garbage data to show it is ignored.
    task automatic run(input int w, input logic [7:0] d, input int stall);
        logic [8:0] exp;
        exp = model(w, d);
        @(posedge clk); #1;
        chk("idle_ctl", ctl(w), 3'b010);
        drive(w, 1'b1, d);
        @(posedge clk); #1;
        chk("accept_ctl", ctl(w), 3'b001);
        drive(w, 1'b1, 8'($urandom));
        for (int j = 1; j <= w - 1; j++) begin
            @(posedge clk); #1;
            if (j < w - 1) chk("shift_ctl", ctl(w), 3'b001);
            drive(w, 1'b1, 8'($urandom));
        end
        chk("done_ctl", ctl(w), 3'b101);
        chk("result", res_of(w), exp);
        for (int s = 0; s < stall; s++) begin
            set_ready(w, 1'b0);
            @(posedge clk); #1;
            chk("stall_ctl", ctl(w), 3'b101);
            chk("stall_hold", res_of(w), exp);
        end
        set_ready(w, 1'b1);
        @(posedge clk); #1;
        set_ready(w, 1'b0);
        drive(w, 1'b0, 8'($urandom));
        chk("release_ctl", ctl(w), 3'b010);
    endtask

    initial begin
        rst_n = 1'b0;
        iv3 = 1'b0; id3 = '0; or3 = 1'b0;
        iv8 = 1'b0; id8 = '0; or8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl3", ctl(3), 3'b010);
        chk("reset_res3", res_of(3), 9'h000);
        chk("reset_ctl8", ctl(8), 3'b010);
        chk("reset_res8", res_of(8), 9'h000);
        rst_n = 1'b1;

        run(3, 8'h03, 0);
        run(3, 8'h07, 1);
        run(3, 8'h06, 0);
        run(3, 8'h05, 2);
        run(3, 8'h04, 0);
        run(3, 8'h00, 0);
        run(8, 8'h80, 0);
        run(8, 8'hF6, 0);
        run(8, 8'h00, 0);
        run(8, 8'h7F, 1);
        run(8, 8'h81, 0);

        // Long backpressure, then the next word right after release.
        run(3, 8'h01, 5);
        run(3, 8'h02, 0);

        // Reset during the first SHIFT cycle drops the word.
        @(posedge clk); #1;
        drive(8, 1'b1, 8'h9C);
        @(posedge clk); #1;
        drive(8, 1'b0, 8'h00);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_ctl", ctl(8), 3'b010);
        chk("rst_mid_res", res_of(8), 9'h000);
        repeat (10) begin
            @(posedge clk); #1;
            chk("rst_no_result", ctl(8), 3'b010);
        end
        run(8, 8'hF6, 0);

        for (int i = 0; i < 20; i++) begin
            run(3, 8'($urandom), int'($urandom_range(0, 2)));
            run(8, 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/twos_to_sign_mag_serial.md
Name: twos_to_sign_mag_serial

Overview:
Streaming converter from two's-complement to sign-magnitude. It is the inverse of the existing sign-magnitude-to-two's-complement block in the same arithmetic library. The magnitude is negated bit-serially, LSB first, using the copy-through-first-one-then-invert rule, so the datapath needs no MIC-wide adder. Valid/ready handshakes sit on both sides so the block can drop between a producer and a consumer that each stall.

Parameters:
MIC, 3, total word width including sign bit; legal range MIC >= 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  in_data is offered
in_ready  output  1  block can accept a word; high only in IDLE
in_data  input  MIC  two's-complement operand
out_valid  output  1  out_data/out_ovf are valid; held until accepted
out_ready  input  1  consumer accepts the result
out_data  output  MIC  sign-magnitude result: [MIC-1] = sign, [MIC-2:0] = magnitude
out_ovf  output  1  input was the most negative value (unrepresentable); qualified by out_valid
busy  output  1  high in SHIFT or DONE

Behaviour:
- Reset (rst_n low at an edge), from any state:
  - state = IDLE; in_ready = 1 after reset; out_valid, out_data, out_ovf, busy = 0.
  - An in-flight word is discarded and no result is produced for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1, the word is accepted:
    - latch sign = in_data[MIC-1] and shift register sr = in_data[MIC-2:0];
    - clear bit counter cnt, seen_one and the result register;
    - go to SHIFT.
  - With in_valid = 0 the block stays in IDLE.
- SHIFT: runs exactly MIC-1 cycles, one magnitude bit per cycle, LSB first. Each edge:
  - b = sr[0];
  - output bit r = b if sign = 0; otherwise r = (seen_one ? ~b : b);
  - seen_one |= b;
  - r is shifted into the result register from the MSB side so bits end in their original positions;
  - sr shifts right; cnt increments.
  - On the edge where cnt reaches MIC-2 (the last bit), the result and out_ovf are registered and the state goes to DONE.
- DONE:
  - out_valid = 1; out_data and out_ovf are stable.
  - On an edge with out_ready = 1, go to IDLE and clear out_valid.
  - No new word is accepted in the same cycle as the result is accepted.
- Latency and throughput:
  - Acceptance at edge k gives out_valid = 1 after edge k+MIC-1.
  - Minimum throughput is one word per MIC+1 cycles (accept, MIC-1 SHIFT cycles, 1 DONE cycle with out_ready = 1).
- Arithmetic:
  - sign = 0: out_data = in_data unchanged; out_ovf = 0.
  - sign = 1 with magnitude bits not all zero: out_data = {1, (2^(MIC-1) - in_data[MIC-2:0]) mod 2^(MIC-1)}; out_ovf = 0.
  - sign = 1 with magnitude bits all zero (value -2^(MIC-1)): seen_one stays 0, so out_ovf = 1 and out_data saturates to {1, all ones}, i.e. -(2^(MIC-1)-1).
  - Zero input gives out_data = 0 and out_ovf = 0. Negative zero is never produced.
- Backpressure and handshake rules:
  - out_valid stays asserted across any number of out_ready = 0 cycles, with out_data and out_ovf stable.
  - in_data is sampled only on the acceptance edge; later changes to in_data are ignored.
  - in_valid is ignored in SHIFT and DONE.
- Simultaneous events: rst_n low overrides every transition, including acceptance in IDLE and result acceptance in DONE.

Test Plan:
- MIC=3, reset then in_data = 3'b011 (+3) -> out_valid after 2 cycles; out_data = 3'b011; out_ovf = 0.
- MIC=3, sweep 3'b111 / 3'b110 / 3'b101 -> out_data 3'b101 / 3'b110 / 3'b111; out_ovf = 0; in_ready low while busy.
- MIC=3, in_data = 3'b100 (-4) -> out_data = 3'b111, out_ovf = 1. MIC=8, in_data = 8'h80 -> out_data = 8'hFF, out_ovf = 1.
- MIC=8, in_data = 8'hF6 (-10) -> out_data = 8'h8A after 7 cycles. in_data = 8'h00 -> 8'h00.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready = 0. Then a 1-cycle out_ready -> IDLE, next word accepted on the following edge.
- Reset mid-SHIFT: rst_n = 0 for one edge during cycle 1 of SHIFT -> state IDLE, out_valid = 0, no result emitted. The next word converts correctly.
